// File: rtl/frame_scanout.sv
// 64x32x3 frame store with a pixel-write port, a sequential clear engine and a
// raster scan-out producing registered rgb/hsync/vsync/active/frame_start.
module frame_scanout #(
  parameter int         H_FRONT      = 4,
  parameter int         H_SYNC       = 8,
  parameter int         H_BACK       = 4,
  parameter int         V_FRONT      = 1,
  parameter int         V_SYNC       = 2,
  parameter int         V_BACK       = 1,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       plot,
  input  logic [5:0] x,
  input  logic [4:0] y,
  input  logic [2:0] colour,
  input  logic       clear,
  output logic       busy,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [2:0] rgb,
  output logic       frame_start
);

  localparam int H_TOTAL = 64 + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = 32 + V_FRONT + V_SYNC + V_BACK;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);

  typedef enum logic {
    S_IDLE,
    S_CLEARING
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] clr_addr_q, clr_addr_d;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [2:0]  wr_data;

  logic [HCW-1:0] hcount_q, hcount_d;
  logic [VCW-1:0] vcount_q, vcount_d;
  logic [10:0]    rd_addr;

  logic [2:0] mem [0:2047];
  logic [2:0] rd_data_q;

  logic vis_s1_q, vis_s1_d;
  logic hsync_s1_q, hsync_s1_d;
  logic vsync_s1_q, vsync_s1_d;
  logic fs_s1_q, fs_s1_d;

  logic [2:0] rgb_q, rgb_d;
  logic       active_q, active_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       frame_start_q, frame_start_d;

  // Clear engine and write-port arbitration; clear has priority over plot.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wr_en      = 1'b0;
    wr_addr    = {y, x};
    wr_data    = colour;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          state_d    = S_CLEARING;
          clr_addr_d = '0;
        end else if (plot) begin
          wr_en = 1'b1;
        end
      end
      S_CLEARING: begin
        wr_en      = 1'b1;
        wr_addr    = clr_addr_q;
        wr_data    = CLEAR_COLOUR;
        clr_addr_d = clr_addr_q + 11'd1;
        if (clr_addr_q == 11'd2047) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hcount_d = hcount_q + HCW'(1);
    vcount_d = vcount_q;
    if (hcount_q == HCW'(H_TOTAL - 1)) begin
      hcount_d = '0;
      vcount_d = (vcount_q == VCW'(V_TOTAL - 1)) ? '0 : vcount_q + VCW'(1);
    end
  end

  // Stage 1 decodes the counters alongside the memory read; stage 2 registers outputs.
  always_comb begin
    rd_addr       = {vcount_q[4:0], hcount_q[5:0]};
    vis_s1_d      = (hcount_q < HCW'(64)) && (vcount_q < VCW'(32));
    hsync_s1_d    = !((hcount_q >= HCW'(64 + H_FRONT)) &&
                      (hcount_q <  HCW'(64 + H_FRONT + H_SYNC)));
    vsync_s1_d    = !((vcount_q >= VCW'(32 + V_FRONT)) &&
                      (vcount_q <  VCW'(32 + V_FRONT + V_SYNC)));
    fs_s1_d       = (hcount_q == '0) && (vcount_q == '0);
    rgb_d         = vis_s1_q ? rd_data_q : 3'b000;
    active_d      = vis_s1_q;
    hsync_d       = hsync_s1_q;
    vsync_d       = vsync_s1_q;
    frame_start_d = fs_s1_q;
  end

  // Writes are suppressed under reset so an aborted clear stops exactly where it was.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      clr_addr_q    <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      vis_s1_q      <= 1'b0;
      hsync_s1_q    <= 1'b1;
      vsync_s1_q    <= 1'b1;
      fs_s1_q       <= 1'b0;
      rgb_q         <= 3'b000;
      active_q      <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      vis_s1_q      <= vis_s1_d;
      hsync_s1_q    <= hsync_s1_d;
      vsync_s1_q    <= vsync_s1_d;
      fs_s1_q       <= fs_s1_d;
      rgb_q         <= rgb_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign busy        = (state_q == S_CLEARING);
  assign rgb         = rgb_q;
  assign active      = active_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_frame_scanout.sv
// Scoreboard bench: a cycle-indexed reference model predicts every scan-out
// sample and busy, a negedge monitor pops and compares against the DUT.
module tb_frame_scanout;

  localparam int HT = 80;
  localparam int VT = 36;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       plot = 1'b0;
  logic [5:0] x = '0;
  logic [4:0] y = '0;
  logic [2:0] colour = '0;
  logic       clear = 1'b0;
  logic       busy, hsync, vsync, active, frame_start;
  logic [2:0] rgb;

  always #5 clk = ~clk;

  frame_scanout dut (
    .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
    .clear(clear), .busy(busy), .hsync(hsync), .vsync(vsync),
    .active(active), .rgb(rgb), .frame_start(frame_start)
  );

  typedef struct {
    int         due;
    logic       hs;
    logic       vs;
    logic       act;
    logic       fs;
    logic [2:0] rgb;
    bit         rgb_known;
  } exp_t;

  exp_t       q[$];
  logic [2:0] mem_m   [2048];
  bit         known_m [2048];
  int         edge_cnt = 0;
  int         cyc = 0;
  int         clear_left = 0;
  int         mh = 0;
  int         mv = 0;
  bit         busy_exp = 1'b0;
  int         tests = 0;
  int         fails = 0;

  // Reference model: position = cycles since reset release; store read before write.
  initial begin : model
    exp_t e;
    int h, v, a;
    forever begin
      @(posedge clk);
      if (reset) begin
        q.delete();
        clear_left = 0;
        cyc = 0;
        e = '{due: edge_cnt, hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0,
              rgb: 3'd0, rgb_known: 1'b1};
        q.push_back(e);
        e.due = edge_cnt + 1;
        q.push_back(e);
      end else begin
        h = cyc % HT;
        v = (cyc / HT) % VT;
        a = (v % 32) * 64 + (h % 64);
        e.due = edge_cnt + 1;
        e.act = (h < 64) && (v < 32);
        e.hs  = !((h >= 68) && (h < 76));
        e.vs  = !((v >= 33) && (v < 35));
        e.fs  = (h == 0) && (v == 0);
        e.rgb = e.act ? mem_m[a] : 3'd0;
        e.rgb_known = e.act ? known_m[a] : 1'b1;
        q.push_back(e);
        if (clear_left > 0) begin
          mem_m[2048 - clear_left] = 3'd0;
          known_m[2048 - clear_left] = 1'b1;
          clear_left--;
        end else if (clear) begin
          clear_left = 2048;
        end else if (plot) begin
          mem_m[{y, x}] = colour;
          known_m[{y, x}] = 1'b1;
        end
        cyc++;
      end
      busy_exp = (clear_left > 0);
      mh = cyc % HT;
      mv = (cyc / HT) % VT;
      edge_cnt++;
    end
  end

  initial begin : monitor
    exp_t e;
    int last;
    forever begin
      @(negedge clk);
      if (edge_cnt > 0) begin
        last = edge_cnt - 1;
        tests++;
        if (busy !== busy_exp) begin
          fails++;
          $display("FAIL busy edge=%0d: got %b want %b", last, busy, busy_exp);
        end
        while (q.size() > 0 && q[0].due <= last) begin
          e = q.pop_front();
          tests++;
          if (e.due != last) begin
            fails++;
            $display("FAIL stale_expect edge=%0d: entry due %0d never checked", last, e.due);
          end else if (hsync !== e.hs || vsync !== e.vs || active !== e.act ||
                       frame_start !== e.fs || (e.rgb_known && rgb !== e.rgb)) begin
            fails++;
            $display("FAIL scan edge=%0d: got hs=%b vs=%b act=%b fs=%b rgb=%0d want hs=%b vs=%b act=%b fs=%b rgb=%0d(known=%0d)",
                     last, hsync, vsync, active, frame_start, rgb,
                     e.hs, e.vs, e.act, e.fs, e.rgb, e.rgb_known);
          end
        end
      end
    end
  end

  task automatic drive(input bit p, input int xx, input int yy, input int cc,
                       input bit clr, input bit rst);
    @(negedge clk);
    plot   = p;
    x      = 6'(xx);
    y      = 5'(yy);
    colour = 3'(cc);
    clear  = clr;
    reset  = rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin : stimulus
    bit found;
    for (int i = 0; i < 3; i++) drive(1'b0, 0, 0, 0, 1'b0, 1'b1);
    idle(2 * FRAME + 10);

    drive(1'b0, 0, 0, 0, 1'b1, 1'b0);
    idle(2048 + FRAME + 100);

    drive(1'b1, 0, 0, 7, 1'b0, 1'b0);
    drive(1'b1, 63, 31, 5, 1'b0, 1'b0);
    drive(1'b1, 10, 3, 2, 1'b0, 1'b0);
    idle(FRAME + 100);

    drive(1'b0, 0, 0, 0, 1'b1, 1'b0);
    drive(1'b1, 5, 5, 6, 1'b0, 1'b0);
    idle(2100);
    drive(1'b1, 7, 7, 3, 1'b1, 1'b0);
    idle(2100 + FRAME);

    // Plot into the pixel being read on that very edge.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
      if (mh == 10 && mv == 4) begin
        plot = 1'b1; x = 6'd10; y = 5'd4; colour = 3'd6;
        found = 1'b1;
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL same_edge_wait: got timeout want counter at (10,4)");
    end
    idle(2 * FRAME);

    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 63), $urandom_range(0, 31),
            $urandom_range(1, 7), 1'b0, 1'b0);
    idle(FRAME + 100);

    // Reset 1000 edges into a clear: only addresses 0..998 get cleared.
    drive(1'b0, 0, 0, 0, 1'b1, 1'b0);
    idle(999);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b1);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b1);
    idle(FRAME + 100);

    for (int i = 0; i < 500; i++)
      drive(1'b1, $urandom_range(0, 63), $urandom_range(0, 31),
            $urandom_range(0, 7), 1'b0, 1'b0);
    idle(FRAME + 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
